// File: rtl/ip_periph_pkg.sv
// ip_periph_pkg
//   Shared constants for the input-peripheral register bank: register word
//   indices inside the 32 B window, the window size and the per-button
//   debounce state encoding.
package ip_periph_pkg;

  // Window size in bytes; the bank decodes address bits [4:2] as word index.
  localparam int IP_WIN_BYTES = 32;

  localparam logic [2:0] IP_IDX_SW    = 3'd0;
  localparam logic [2:0] IP_IDX_BTN   = 3'd1;
  localparam logic [2:0] IP_IDX_RISE  = 3'd2;
  localparam logic [2:0] IP_IDX_FALL  = 3'd3;
  localparam logic [2:0] IP_IDX_SWCHG = 3'd4;
  localparam logic [2:0] IP_IDX_IRQEN = 3'd5;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_PEND   = 1'b1
  } db_state_e;

endpackage

// File: rtl/ip_debounce.sv
// ip_debounce
//   One push-button: synchronizer chain, debounce counter/FSM, accepted level
//   and single-cycle rise/fall pulses on the cycle the new level is accepted.
// Ports
//   i_clk    clock
//   i_rst    asynchronous active-low reset
//   i_btn    raw asynchronous button input (active high)
//   o_level  debounced level
//   o_rise   pulse: level is being accepted as 1 at the coming edge
//   o_fall   pulse: level is being accepted as 0 at the coming edge
module ip_debounce
  import ip_periph_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 20000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  // One extra count value so DB_CYCLES itself fits; the counter is reset on
  // acceptance so it never wraps.
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   btn_s;
  logic                   accept;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_btn};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    case (state_q)
      DB_STABLE: begin
        cnt_d = '0;
        if (btn_s != level_q) state_d = DB_PEND;
      end
      DB_PEND: begin
        if (btn_s == level_q) begin
          // Glitch ended before it was held long enough: drop partial count.
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
          accept  = 1'b1;
          level_d = btn_s;
          cnt_d   = '0;
          state_d = DB_STABLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q  <= '0;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = accept & btn_s;
  assign o_fall  = accept & ~btn_s;

endmodule

// File: rtl/ip_periph_bank.sv
// ip_periph_bank
//   Memory-mapped input-peripheral bank on the LSU load path. Synchronizes
//   SW_W switches, debounces BTN_N buttons, keeps sticky W1C edge/change
//   flags and serves a 32 B window at BASE_ADDR with one-cycle read latency.
//   Optional feature macro: IP_IRQ_EN adds the IRQEN register (idx 5) and
//   the o_irq level interrupt output.
// Ports
//   i_clk       clock
//   i_rst       asynchronous active-low reset
//   i_lsu_wren  store strobe
//   i_lsu_addr  byte address
//   i_st_data   store data (W1C masks / IRQEN value)
//   i_io_sw     raw switches
//   i_io_btn    raw buttons, active high
//   o_ip_data   registered read data (0 outside the window)
//   o_irq       registered level interrupt (IP_IRQ_EN only)
//   o_ip_hit    registered window hit of the previous cycle's address
module ip_periph_bank
  import ip_periph_pkg::*;
#(
  parameter int          SW_W        = 32,
  parameter int          BTN_N       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          DB_CYCLES   = 20000,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_7800
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_lsu_wren,
  input  logic [31:0]      i_lsu_addr,
  input  logic [31:0]      i_st_data,
  input  logic [SW_W-1:0]  i_io_sw,
  input  logic [BTN_N-1:0] i_io_btn,
  output logic [31:0]      o_ip_data,
`ifdef IP_IRQ_EN
  output logic             o_irq,
`endif
  output logic             o_ip_hit
);

  localparam int AW = $clog2(IP_WIN_BYTES);

  // Switch synchronizer plus one history flop used for change detection.
  logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync_q, sw_sync_d;
  logic [SW_W-1:0]                  sw_s, sw_prev_q;

  always_comb begin
    sw_sync_d[0] = i_io_sw;
    for (int k = 1; k < SYNC_STAGES; k++) sw_sync_d[k] = sw_sync_q[k-1];
  end
  assign sw_s = sw_sync_q[SYNC_STAGES-1];

  logic [BTN_N-1:0] btn_level, btn_rise, btn_fall;

  for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
    ip_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_db (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_btn  (i_io_btn[gi]),
      .o_level(btn_level[gi]),
      .o_rise (btn_rise[gi]),
      .o_fall (btn_fall[gi])
    );
  end

  logic       hit, wr_en;
  logic [2:0] idx;
  assign hit   = (i_lsu_addr[31:AW] == BASE_ADDR[31:AW]);
  assign idx   = i_lsu_addr[AW-1:2];
  assign wr_en = i_lsu_wren & hit;

  // Byte offset and store bits beyond the flag widths have no effect.
  logic unused_bits;
  assign unused_bits = ^{i_lsu_addr[1:0], i_st_data};

  logic [BTN_N-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [SW_W-1:0]  swchg_q, swchg_d;

  // Clear first, then OR in new events so a same-cycle set is never lost.
  always_comb begin
    rise_d  = rise_q;
    fall_d  = fall_q;
    swchg_d = swchg_q;
    if (wr_en && idx == IP_IDX_RISE)  rise_d  = rise_q  & ~i_st_data[BTN_N-1:0];
    if (wr_en && idx == IP_IDX_FALL)  fall_d  = fall_q  & ~i_st_data[BTN_N-1:0];
    if (wr_en && idx == IP_IDX_SWCHG) swchg_d = swchg_q & ~i_st_data[SW_W-1:0];
    rise_d  = rise_d  | btn_rise;
    fall_d  = fall_d  | btn_fall;
    swchg_d = swchg_d | (sw_s ^ sw_prev_q);
  end

`ifdef IP_IRQ_EN
  logic [2:0] irqen_q, irqen_d;
  logic       irq_q, irq_d;

  always_comb begin
    irqen_d = irqen_q;
    if (wr_en && idx == IP_IDX_IRQEN) irqen_d = i_st_data[2:0];
    irq_d = (|(rise_q  & {BTN_N{irqen_q[0]}})) |
            (|(fall_q  & {BTN_N{irqen_q[1]}})) |
            (|(swchg_q & {SW_W{irqen_q[2]}}));
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      irqen_q <= irqen_d;
      irq_q   <= irq_d;
    end
  end

  assign o_irq = irq_q;
`endif

  logic [31:0] rd_word;
  logic [31:0] ip_data_q, ip_data_d;
  logic        ip_hit_q, ip_hit_d;

  always_comb begin
    rd_word = '0;
    case (idx)
      IP_IDX_SW:    rd_word[SW_W-1:0]  = sw_s;
      IP_IDX_BTN:   rd_word[BTN_N-1:0] = btn_level;
      IP_IDX_RISE:  rd_word[BTN_N-1:0] = rise_q;
      IP_IDX_FALL:  rd_word[BTN_N-1:0] = fall_q;
      IP_IDX_SWCHG: rd_word[SW_W-1:0]  = swchg_q;
`ifdef IP_IRQ_EN
      IP_IDX_IRQEN: rd_word[2:0]       = irqen_q;
`endif
      default:      rd_word            = '0;
    endcase
    ip_data_d = hit ? rd_word : 32'h0;
    ip_hit_d  = hit;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sw_sync_q <= '0;
      sw_prev_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      swchg_q   <= '0;
      ip_data_q <= '0;
      ip_hit_q  <= 1'b0;
    end else begin
      sw_sync_q <= sw_sync_d;
      sw_prev_q <= sw_s;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      swchg_q   <= swchg_d;
      ip_data_q <= ip_data_d;
      ip_hit_q  <= ip_hit_d;
    end
  end

  assign o_ip_data = ip_data_q;
  assign o_ip_hit  = ip_hit_q;

endmodule

// File: tb/tb_ip_periph_bank.sv
// tb_ip_periph_bank
//   Directed and randomized stimulus for ip_periph_bank (DB_CYCLES=8),
//   checked every cycle against a history-based reference model.
module tb_ip_periph_bank;

  localparam int          S    = 2;
  localparam int          DB   = 8;
  localparam logic [31:0] BASE = 32'h0000_7800;
  localparam int          HN   = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wren;
  logic [31:0] addr, st_data, io_sw, o_data;
  logic [3:0]  io_btn;
  logic        o_hit;
`ifdef IP_IRQ_EN
  logic        o_irq;
`endif

  always #5 clk = ~clk;

  ip_periph_bank #(
    .SW_W(32), .BTN_N(4), .SYNC_STAGES(S), .DB_CYCLES(DB), .BASE_ADDR(BASE)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_lsu_wren(wren),
    .i_lsu_addr(addr),
    .i_st_data (st_data),
    .i_io_sw   (io_sw),
    .i_io_btn  (io_btn),
    .o_ip_data (o_data),
`ifdef IP_IRQ_EN
    .o_irq     (o_irq),
`endif
    .o_ip_hit  (o_hit)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: raw input history per sampling edge since reset.
  logic [31:0] sw_hist  [HN];
  logic [3:0]  btn_hist [HN];
  int          cyc;
  logic [3:0]  m_level, m_rise, m_fall;
  logic [31:0] m_swchg;
  int          m_last [4];
`ifdef IP_IRQ_EN
  logic [2:0]  m_irqen;
`endif
  logic [31:0] cur_sw, last_rd;
  logic [3:0]  cur_btn;
  logic        last_hit;

  function automatic logic [31:0] sw_at(input int k);
    if (k < 1) return 32'h0;
    return sw_hist[k];
  endfunction

  function automatic logic [3:0] btn_at(input int k);
    if (k < 1) return 4'h0;
    return btn_hist[k];
  endfunction

  // Register contents as seen after edge cyc.
  function automatic logic [31:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0: return sw_at(cyc - S + 1);
      3'd1: return {28'h0, m_level};
      3'd2: return {28'h0, m_rise};
      3'd3: return {28'h0, m_fall};
      3'd4: return m_swchg;
`ifdef IP_IRQ_EN
      3'd5: return {29'h0, m_irqen};
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Apply edge cyc: a button level is accepted once its synchronized value has
  // differed from the level for DB+1 consecutive cycles since the last change.
  task automatic model_update(input logic we, input logic h, input logic [2:0] idx,
                              input logic [31:0] d);
    logic [31:0] sw_set;
    logic [3:0]  r_set, f_set, smp;
    bit          acc;
    sw_set = sw_at(cyc - S) ^ sw_at(cyc - S - 1);
    r_set = '0;
    f_set = '0;
    for (int b = 0; b < 4; b++) begin
      acc = (cyc - DB >= m_last[b] + 1);
      for (int m = cyc - DB; m <= cyc; m++) begin
        smp = btn_at(m - S);
        if (smp[b] == m_level[b]) acc = 0;
      end
      if (acc) begin
        if (m_level[b]) f_set[b] = 1'b1;
        else            r_set[b] = 1'b1;
        m_level[b] = ~m_level[b];
        m_last[b]  = cyc;
      end
    end
    if (we && h && idx == 3'd2) m_rise  = m_rise  & ~d[3:0];
    if (we && h && idx == 3'd3) m_fall  = m_fall  & ~d[3:0];
    if (we && h && idx == 3'd4) m_swchg = m_swchg & ~d;
`ifdef IP_IRQ_EN
    if (we && h && idx == 3'd5) m_irqen = d[2:0];
`endif
    m_rise  = m_rise  | r_set;
    m_fall  = m_fall  | f_set;
    m_swchg = m_swchg | sw_set;
  endtask

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d, input bit show);
    logic [31:0] exp_d;
    logic        exp_h;
`ifdef IP_IRQ_EN
    logic        exp_irq;
`endif
    @(negedge clk);
    wren = we; addr = a; st_data = d; io_sw = cur_sw; io_btn = cur_btn;
    @(posedge clk);
    exp_h = (a[31:5] == BASE[31:5]);
    exp_d = exp_h ? model_read(a[4:2]) : 32'h0;
`ifdef IP_IRQ_EN
    exp_irq = (|(m_rise & {4{m_irqen[0]}})) | (|(m_fall & {4{m_irqen[1]}})) |
              (|(m_swchg & {32{m_irqen[2]}}));
`endif
    cyc++;
    if (cyc >= HN) begin
      $display("FAIL history_overflow: got %0d expected below %0d", cyc, HN);
      $fatal(1, "model history exhausted");
    end
    sw_hist[cyc]  = cur_sw;
    btn_hist[cyc] = cur_btn;
    model_update(we, exp_h, a[4:2], d);
    #1;
    check("rdata", o_data, exp_d);
    check("hit", {31'h0, o_hit}, {31'h0, exp_h});
`ifdef IP_IRQ_EN
    check("irq", {31'h0, o_irq}, {31'h0, exp_irq});
`endif
    last_rd  = o_data;
    last_hit = o_hit;
    if (show) $display("txn cyc=%0d we=%0b addr=%h wdata=%h rdata=%h hit=%0b sw=%h btn=%h",
                       cyc, we, a, d, o_data, o_hit, cur_sw, cur_btn);
  endtask

  task automatic do_reset(input bit zero_after);
    @(negedge clk);
    rst_n = 1'b0;
    wren = 1'($urandom); addr = BASE | ($urandom & 32'h1C); st_data = $urandom;
    io_sw = $urandom; io_btn = 4'($urandom);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_rdata", o_data, 32'h0);
      check("rst_hit", {31'h0, o_hit}, 32'h0);
`ifdef IP_IRQ_EN
      check("rst_irq", {31'h0, o_irq}, 32'h0);
`endif
    end
    rst_n = 1'b1;
    cyc = 0; m_level = '0; m_rise = '0; m_fall = '0; m_swchg = '0;
    for (int b = 0; b < 4; b++) m_last[b] = 0;
`ifdef IP_IRQ_EN
    m_irqen = '0;
`endif
    if (zero_after) begin cur_sw = '0; cur_btn = '0; end
    else            begin cur_sw = io_sw; cur_btn = io_btn; end
    $display("txn reset released, sw=%h btn=%h", cur_sw, cur_btn);
  endtask

  task automatic rand_step();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) cur_sw = cur_sw ^ (32'h1 << $urandom_range(0, 31));
    for (int b = 0; b < 4; b++)
      if ($urandom_range(0, 11) == 0) cur_btn[b] = ~cur_btn[b];
    a = 32'h77E0 + 32'($urandom_range(0, 23) * 4) + 32'($urandom_range(0, 3));
    step($urandom_range(0, 3) == 0, a, $urandom, 1'b0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; wren = 1'b0; addr = '0; st_data = '0; io_sw = '0; io_btn = '0;
    cur_sw = '0; cur_btn = '0; last_rd = '0; last_hit = 1'b0; cyc = 0;

    // Reset with random inputs, then read the whole window with quiet inputs.
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, BASE + 32'(4 * i), 32'h0, 1'b1);
      check("t1_zero", last_rd, 32'h0);
    end

    // Switch path and SWCHG latency.
    cur_sw = 32'hA5A5_0001;
    lat = 0;
    for (int s = 1; s <= 8; s++) begin
      step(1'b0, 32'h7810, 32'h0, 1'b1);
      if (lat == 0 && last_rd != 0) lat = s;
    end
    check("t2_swchg_lat", 32'(lat), 32'(S + 2));
    step(1'b0, 32'h7800, 32'h0, 1'b1); check("t2_sw", last_rd, 32'hA5A5_0001);
    step(1'b0, 32'h7810, 32'h0, 1'b1); check("t2_swchg", last_rd, 32'hA5A5_0001);
    step(1'b1, 32'h7810, 32'h1, 1'b1);
    step(1'b0, 32'h7810, 32'h0, 1'b1); check("t2_w1c", last_rd, 32'hA5A5_0000);

    // Debounce: a 5-cycle glitch is rejected, a long press is accepted.
    cur_btn = 4'h1;
    repeat (5) step(1'b0, 32'h7804, 32'h0, 1'b1);
    cur_btn = 4'h0;
    repeat (15) step(1'b0, 32'h7808, 32'h0, 1'b1);
    check("t3_glitch_rise", last_rd, 32'h0);
    step(1'b0, 32'h7804, 32'h0, 1'b1); check("t3_glitch_btn", last_rd, 32'h0);
    cur_btn = 4'h1;
    lat = 0;
    for (int s = 1; s <= 20; s++) begin
      step(1'b0, 32'h7808, 32'h0, 1'b1);
      if (lat == 0 && last_rd[0]) lat = s;
    end
    check("t3_rise_lat", 32'(lat), 32'(S + DB + 2));
    step(1'b0, 32'h7804, 32'h0, 1'b1); check("t3_btn", last_rd, 32'h1);

    // W1C racing a new rise pulse: the set wins.
    cur_btn = 4'h0;
    repeat (14) step(1'b0, 32'h0, 32'h0, 1'b1);
    cur_btn = 4'h1;
    repeat (10) step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 32'h7808, 32'h1, 1'b1);
    step(1'b1, 32'h7808, 32'h1, 1'b1); check("t4_race_kept", last_rd, 32'h1);
    step(1'b0, 32'h7808, 32'h0, 1'b1); check("t4_cleared", last_rd, 32'h0);
    step(1'b0, 32'h780C, 32'h0, 1'b1); check("t4_fall", last_rd, 32'h1);

    // Window decode and aliasing.
    step(1'b0, 32'h7820, 32'h0, 1'b1);
    check("t5_above_data", last_rd, 32'h0); check("t5_above_hit", {31'h0, last_hit}, 32'h0);
    step(1'b0, 32'h77FC, 32'h0, 1'b1);
    check("t5_below_data", last_rd, 32'h0); check("t5_below_hit", {31'h0, last_hit}, 32'h0);
    step(1'b0, 32'h781B, 32'h0, 1'b1);
    check("t5_alias_hit", {31'h0, last_hit}, 32'h1); check("t5_alias_data", last_rd, 32'h0);
    step(1'b1, 32'h7804, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 32'h7805, 32'h0, 1'b1); check("t5_btn_ro", last_rd, 32'h1);

`ifdef IP_IRQ_EN
    step(1'b1, 32'h7814, 32'h1, 1'b1);
    cur_btn = 4'h3;
    repeat (14) step(1'b0, 32'h7814, 32'h0, 1'b1);
    check("t6_irqen", last_rd, 32'h1);
    check("t6_irq_set", {31'h0, o_irq}, 32'h1);
    step(1'b1, 32'h7808, 32'h2, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check("t6_irq_clr", {31'h0, o_irq}, 32'h0);
`else
    step(1'b1, 32'h7814, 32'h7, 1'b1);
    step(1'b0, 32'h7814, 32'h0, 1'b1); check("t6_idx5_zero", last_rd, 32'h0);
`endif

    // Random traffic, a reset with inputs already high, more random traffic.
    repeat (600) rand_step();
    do_reset(1'b0);
    repeat (600) rand_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
